// File: rtl/stopwatch_pkg.sv
// Shared constants and state encoding for the stopwatch lap controller.
// The default parameters describe the standard 4-lap, 0.1 s resolution build.
package stopwatch_pkg;

    localparam int DEF_MEM_SIZE   = 4;
    localparam int DEF_TIME_WIDTH = 14;
    localparam int DEF_MAX_TIME   = 9999;
    localparam int DEF_IDX_WIDTH  = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        STOPPED = 2'd2,
        REVIEW  = 2'd3
    } state_t;

endpackage

// File: rtl/stopwatch_lap_controller_if.sv
// Button/timer pulses into the controller and display values out of it.
// Signal suffixes are from the controller's point of view (slave modport).
interface stopwatch_lap_controller_if #(
    parameter int TIME_WIDTH = 14,
    parameter int IDX_WIDTH  = 3
);

    logic                  start_stop_i;
    logic                  lap_i;
    logic                  show_i;
    logic                  clear_i;
    logic                  tick_i;

    logic                  running_o;
    logic [TIME_WIDTH-1:0] show_time_o;
    logic [TIME_WIDTH-1:0] lap_delta_o;
    logic [IDX_WIDTH-1:0]  lap_count_o;
    logic [IDX_WIDTH-1:0]  show_idx_o;
    logic                  mem_full_o;

    modport slave (
        input  start_stop_i, lap_i, show_i, clear_i, tick_i,
        output running_o, show_time_o, lap_delta_o, lap_count_o, show_idx_o, mem_full_o
    );

    modport master (
        output start_stop_i, lap_i, show_i, clear_i, tick_i,
        input  running_o, show_time_o, lap_delta_o, lap_count_o, show_idx_o, mem_full_o
    );

endinterface

// File: rtl/stopwatch_lap_mem.sv
// Lap register file: one synchronous write port, one combinational read port,
// async reset plus a synchronous clear used by soft clear and stopwatch reset.
module stopwatch_lap_mem #(
    parameter int MEM_SIZE   = 4,
    parameter int TIME_WIDTH = 14,
    parameter int IDX_WIDTH  = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr_i,
    input  logic                  we_i,
    input  logic [IDX_WIDTH-1:0]  wr_addr_i,
    input  logic [TIME_WIDTH-1:0] wr_data_i,
    input  logic [IDX_WIDTH-1:0]  rd_addr_i,
    output logic [TIME_WIDTH-1:0] rd_data_o
);

    logic [TIME_WIDTH-1:0] mem_q [MEM_SIZE];

    // Address decode by comparison keeps the index width independent of MEM_SIZE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MEM_SIZE; i++) mem_q[i] <= '0;
        end else if (clr_i) begin
            for (int i = 0; i < MEM_SIZE; i++) mem_q[i] <= '0;
        end else if (we_i) begin
            for (int i = 0; i < MEM_SIZE; i++) begin
                if (wr_addr_i == IDX_WIDTH'(i)) mem_q[i] <= wr_data_i;
            end
        end
    end

    always_comb begin
        rd_data_o = '0;
        for (int i = 0; i < MEM_SIZE; i++) begin
            if (rd_addr_i == IDX_WIDTH'(i)) rd_data_o = mem_q[i];
        end
    end

endmodule

// File: rtl/stopwatch_lap_controller.sv
// Stopwatch control FSM: elapsed-time counter, lap capture with delta,
// and selection of the live count or a stored lap for the display.
module stopwatch_lap_controller
    import stopwatch_pkg::*;
#(
    parameter int MEM_SIZE   = DEF_MEM_SIZE,
    parameter int TIME_WIDTH = DEF_TIME_WIDTH,
    parameter int MAX_TIME   = DEF_MAX_TIME,
    parameter int IDX_WIDTH  = DEF_IDX_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst,
    stopwatch_lap_controller_if.slave  bus
);

    localparam logic [TIME_WIDTH-1:0] MAX_T   = TIME_WIDTH'(MAX_TIME);
    localparam logic [TIME_WIDTH:0]   MODULUS = (TIME_WIDTH+1)'(MAX_TIME + 1);
    localparam logic [IDX_WIDTH-1:0]  FULL    = IDX_WIDTH'(MEM_SIZE);

    state_t                state_q, state_d;
    logic [TIME_WIDTH-1:0] count_q, count_d;
    logic [TIME_WIDTH-1:0] last_lap_q, last_lap_d;
    logic [TIME_WIDTH-1:0] lap_delta_q, lap_delta_d;
    logic [IDX_WIDTH-1:0]  lap_count_q, lap_count_d;
    logic [IDX_WIDTH-1:0]  show_idx_q, show_idx_d;

    logic                  mem_we, mem_clr;
    logic [IDX_WIDTH-1:0]  rd_addr;
    logic [TIME_WIDTH-1:0] rd_data;
    logic [TIME_WIDTH-1:0] count_inc;
    logic [TIME_WIDTH:0]   diff;

    stopwatch_lap_mem #(
        .MEM_SIZE   (MEM_SIZE),
        .TIME_WIDTH (TIME_WIDTH),
        .IDX_WIDTH  (IDX_WIDTH)
    ) u_mem (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (mem_clr),
        .we_i      (mem_we),
        .wr_addr_i (lap_count_q),
        .wr_data_i (count_q),
        .rd_addr_i (rd_addr),
        .rd_data_o (rd_data)
    );

    // One extra bit keeps the modulo correction from overflowing.
    always_comb begin
        count_inc = (count_q == MAX_T) ? '0 : count_q + TIME_WIDTH'(1);
        if (count_q >= last_lap_q) diff = {1'b0, count_q} - {1'b0, last_lap_q};
        else                       diff = {1'b0, count_q} + MODULUS - {1'b0, last_lap_q};
    end

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        last_lap_d  = last_lap_q;
        lap_delta_d = lap_delta_q;
        lap_count_d = lap_count_q;
        show_idx_d  = show_idx_q;
        mem_we      = 1'b0;
        mem_clr     = 1'b0;

        if (bus.clear_i) begin
            state_d     = IDLE;
            count_d     = '0;
            last_lap_d  = '0;
            lap_delta_d = '0;
            lap_count_d = '0;
            show_idx_d  = '0;
            mem_clr     = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start_stop_i) state_d = RUN;
                end
                RUN: begin
                    if (bus.tick_i) count_d = count_inc;
                    if (bus.start_stop_i) begin
                        state_d = STOPPED;
                    end else if (bus.lap_i) begin
                        lap_delta_d = TIME_WIDTH'(diff);
                        last_lap_d  = count_q;
                        if (lap_count_q < FULL) begin
                            mem_we      = 1'b1;
                            lap_count_d = lap_count_q + IDX_WIDTH'(1);
                        end
                    end
                end
                STOPPED, REVIEW: begin
                    if (bus.start_stop_i) begin
                        state_d    = RUN;
                        show_idx_d = '0;
                    end else if (bus.lap_i) begin
                        // Stopwatch reset: same as clear but reached via lap while halted.
                        state_d     = IDLE;
                        count_d     = '0;
                        last_lap_d  = '0;
                        lap_delta_d = '0;
                        lap_count_d = '0;
                        show_idx_d  = '0;
                        mem_clr     = 1'b1;
                    end else if (bus.show_i) begin
                        if (state_q == STOPPED) begin
                            if (lap_count_q != '0) begin
                                state_d    = REVIEW;
                                show_idx_d = IDX_WIDTH'(1);
                            end
                        end else if (show_idx_q == lap_count_q) begin
                            state_d    = STOPPED;
                            show_idx_d = '0;
                        end else begin
                            show_idx_d = show_idx_q + IDX_WIDTH'(1);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            count_q     <= '0;
            last_lap_q  <= '0;
            lap_delta_q <= '0;
            lap_count_q <= '0;
            show_idx_q  <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            last_lap_q  <= last_lap_d;
            lap_delta_q <= lap_delta_d;
            lap_count_q <= lap_count_d;
            show_idx_q  <= show_idx_d;
        end
    end

    assign rd_addr         = show_idx_q - IDX_WIDTH'(1);
    assign bus.show_time_o = (show_idx_q == '0) ? count_q : rd_data;
    assign bus.running_o   = (state_q == RUN);
    assign bus.mem_full_o  = (lap_count_q == FULL);
    assign bus.lap_delta_o = lap_delta_q;
    assign bus.lap_count_o = lap_count_q;
    assign bus.show_idx_o  = show_idx_q;

endmodule

// File: tb/tb_stopwatch_lap_controller.sv
// Directed bench for the stopwatch lap controller; expected values are hand-computed.
module tb_stopwatch_lap_controller;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   assertions = 0;
    int   failures   = 0;

    stopwatch_lap_controller_if #(.TIME_WIDTH(14), .IDX_WIDTH(3)) bus ();

    stopwatch_lap_controller #(
        .MEM_SIZE(4), .TIME_WIDTH(14), .MAX_TIME(9999), .IDX_WIDTH(3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Hold the given pulses for a number of cycles, then release them #1 after the edge.
    task automatic applyStimulus(input logic ss, input logic lp, input logic sh,
                                 input logic cl, input logic tk, input int cycles);
        bus.start_stop_i = ss;
        bus.lap_i        = lp;
        bus.show_i       = sh;
        bus.clear_i      = cl;
        bus.tick_i       = tk;
        repeat (cycles) @(posedge clk);
        #1;
        bus.start_stop_i = 1'b0;
        bus.lap_i        = 1'b0;
        bus.show_i       = 1'b0;
        bus.clear_i      = 1'b0;
        bus.tick_i       = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertions++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic checkZero(input string tag);
        checkOutput({tag, "_running"},   32'(bus.running_o),   0);
        checkOutput({tag, "_show_time"}, 32'(bus.show_time_o), 0);
        checkOutput({tag, "_lap_delta"}, 32'(bus.lap_delta_o), 0);
        checkOutput({tag, "_lap_count"}, 32'(bus.lap_count_o), 0);
        checkOutput({tag, "_show_idx"},  32'(bus.show_idx_o),  0);
        checkOutput({tag, "_mem_full"},  32'(bus.mem_full_o),  0);
    endtask

    initial begin
        bus.start_stop_i = 1'b0;
        bus.lap_i        = 1'b0;
        bus.show_i       = 1'b0;
        bus.clear_i      = 1'b0;
        bus.tick_i       = 1'b0;

        #12;
        checkZero("reset");
        #10 rst = 1'b0;
        @(posedge clk); #1;

        // Start, count 25, stop; further ticks are ignored while stopped.
        applyStimulus(1, 0, 0, 0, 0, 1);
        checkOutput("start_running", 32'(bus.running_o), 1);
        applyStimulus(0, 0, 0, 0, 1, 25);
        applyStimulus(1, 0, 0, 0, 0, 1);
        checkOutput("stop_running", 32'(bus.running_o), 0);
        checkOutput("stop_time", 32'(bus.show_time_o), 25);
        applyStimulus(0, 0, 0, 0, 1, 5);
        checkOutput("stopped_tick_hold", 32'(bus.show_time_o), 25);
        applyStimulus(0, 1, 0, 0, 0, 1);
        checkOutput("lap_reset_time", 32'(bus.show_time_o), 0);
        checkOutput("lap_reset_running", 32'(bus.running_o), 0);

        // Laps at 10, 30, 31, 35, then a fifth at 40 with the memory full.
        applyStimulus(1, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 1, 10);
        applyStimulus(0, 1, 0, 0, 0, 1);
        checkOutput("lap1_count", 32'(bus.lap_count_o), 1);
        checkOutput("lap1_delta", 32'(bus.lap_delta_o), 10);
        applyStimulus(0, 0, 0, 0, 1, 20);
        applyStimulus(0, 1, 0, 0, 0, 1);
        checkOutput("lap2_delta", 32'(bus.lap_delta_o), 20);
        applyStimulus(0, 0, 0, 0, 1, 1);
        applyStimulus(0, 1, 0, 0, 0, 1);
        checkOutput("lap3_count", 32'(bus.lap_count_o), 3);
        checkOutput("lap3_delta", 32'(bus.lap_delta_o), 1);
        checkOutput("lap3_live", 32'(bus.show_time_o), 31);
        applyStimulus(0, 0, 1, 0, 0, 1);
        checkOutput("run_show_ignored", 32'(bus.show_idx_o), 0);
        applyStimulus(0, 0, 0, 0, 1, 4);
        applyStimulus(0, 1, 0, 0, 0, 1);
        checkOutput("lap4_full", 32'(bus.mem_full_o), 1);
        checkOutput("lap4_count", 32'(bus.lap_count_o), 4);
        applyStimulus(0, 0, 0, 0, 1, 5);
        applyStimulus(0, 1, 0, 0, 0, 1);
        checkOutput("lap5_count", 32'(bus.lap_count_o), 4);
        checkOutput("lap5_delta", 32'(bus.lap_delta_o), 5);

        // Stop and step through all stored laps.
        applyStimulus(1, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 1, 0, 0, 1);
        checkOutput("rev1_idx", 32'(bus.show_idx_o), 1);
        checkOutput("rev1_time", 32'(bus.show_time_o), 10);
        applyStimulus(0, 0, 0, 0, 1, 1);
        checkOutput("rev_tick_ignored", 32'(bus.show_time_o), 10);
        applyStimulus(0, 0, 1, 0, 0, 1);
        checkOutput("rev2_time", 32'(bus.show_time_o), 30);
        applyStimulus(0, 0, 1, 0, 0, 1);
        checkOutput("rev3_time", 32'(bus.show_time_o), 31);
        applyStimulus(0, 0, 1, 0, 0, 1);
        checkOutput("rev4_time", 32'(bus.show_time_o), 35);
        applyStimulus(0, 0, 1, 0, 0, 1);
        checkOutput("rev_wrap_idx", 32'(bus.show_idx_o), 0);
        checkOutput("rev_wrap_live", 32'(bus.show_time_o), 40);
        checkOutput("rev_wrap_running", 32'(bus.running_o), 0);

        // Resume from REVIEW, then clear while reviewing.
        applyStimulus(0, 0, 1, 0, 0, 1);
        applyStimulus(1, 0, 0, 0, 0, 1);
        checkOutput("resume_running", 32'(bus.running_o), 1);
        checkOutput("resume_idx", 32'(bus.show_idx_o), 0);
        checkOutput("resume_time", 32'(bus.show_time_o), 40);
        applyStimulus(1, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 1, 0, 0, 1);
        applyStimulus(0, 0, 0, 1, 0, 1);
        checkZero("clear");
        applyStimulus(0, 0, 1, 0, 1, 1);
        checkOutput("idle_ignore_time", 32'(bus.show_time_o), 0);
        checkOutput("idle_ignore_idx", 32'(bus.show_idx_o), 0);

        // Lap and tick together capture the pre-increment count.
        applyStimulus(1, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 1, 7);
        applyStimulus(0, 1, 0, 0, 1, 1);
        checkOutput("laptick_live", 32'(bus.show_time_o), 8);
        checkOutput("laptick_delta", 32'(bus.lap_delta_o), 7);
        applyStimulus(1, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 1, 0, 0, 1);
        checkOutput("laptick_stored", 32'(bus.show_time_o), 7);

        // Asynchronous reset in the middle of a cycle while running.
        applyStimulus(1, 0, 0, 0, 0, 1);
        checkOutput("pre_async_running", 32'(bus.running_o), 1);
        #2 rst = 1'b1;
        #1;
        checkZero("async_reset");
        #2 rst = 1'b0;
        @(posedge clk); #1;

        // Clear outranks start_stop.
        applyStimulus(1, 0, 0, 1, 0, 1);
        checkOutput("clear_priority", 32'(bus.running_o), 0);

        // Count wrap: lap at 9990, run to 9998, three ticks, lap again.
        applyStimulus(1, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 1, 9990);
        applyStimulus(0, 1, 0, 0, 0, 1);
        checkOutput("wrap_lap1_delta", 32'(bus.lap_delta_o), 9990);
        applyStimulus(0, 0, 0, 0, 1, 8);
        checkOutput("wrap_9998", 32'(bus.show_time_o), 9998);
        applyStimulus(0, 0, 0, 0, 1, 1);
        checkOutput("wrap_9999", 32'(bus.show_time_o), 9999);
        applyStimulus(0, 0, 0, 0, 1, 1);
        checkOutput("wrap_0", 32'(bus.show_time_o), 0);
        applyStimulus(0, 0, 0, 0, 1, 1);
        checkOutput("wrap_1", 32'(bus.show_time_o), 1);
        applyStimulus(0, 1, 0, 0, 0, 1);
        checkOutput("wrap_delta", 32'(bus.lap_delta_o), 11);
        checkOutput("wrap_lap_count", 32'(bus.lap_count_o), 2);

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
